ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter; the opposite direction of the existing PS/2 keyboard receiver (`ps2`) in the 68k system.
- Sends command bytes to the keyboard: LED set 0xED, reset 0xFF, typematic rate 0xF3, and so on.
- Sits beside the receiver on the shared open-drain ps2Clk/ps2Data lines, clocked by clk_cpu.
- Implements the full host request sequence: clock inhibit, start request, device-clocked shift-out, odd parity, stop, device-ack check and timeout.

Parameters:
- c_clk_mhz, 25, system clock frequency in MHz.
- c_inhibit_us, 100, time ps2_clk is held low before the request.
- c_timeout_us, 15000, maximum time from request until the line returns to idle.

Ports:
- clk  in  1  system clock (clk_cpu).
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  request; accepted when tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  raw ps2Clk pin level.
- ps2_data_in  in  1  raw ps2Data pin level.
- ps2_clk_oe  out  1  1 = drive ps2Clk low; 0 = release (pull-up).
- ps2_data_oe  out  1  1 = drive ps2Data low; 0 = release.
- busy  out  1  high in every state except IDLE; the receiver ignores frames while busy.
- done  out  1  one-cycle pulse when a transfer ends, for any reason.
- ack_err  out  1  qualifies done: device did not ack, or stop bit not released.
- timeout  out  1  qualifies done: c_timeout_us elapsed.

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, ack_err=0, timeout=0, tx_ready=1, state IDLE.
- Reset asserted mid-frame releases both lines immediately, because reset is asynchronous.
- Input conditioning: ps2_clk_in and ps2_data_in each pass through a 2-FF synchroniser. A falling edge is sync_clk==0 with previous sync_clk==1, detected one cycle after the second FF.
- Latched on accept: shift register = {1'b1 stop, ~^tx_data odd parity, tx_data}; bit counter = 0.
- IDLE: tx_ready=1. On accept, go to INHIBIT next cycle.
- INHIBIT:
  - ps2_clk_oe=1, ps2_data_oe=0.
  - Hold for N_INH = c_clk_mhz*c_inhibit_us cycles; 2500 at the defaults.
  - Then go to REQ.
- REQ: ps2_data_oe=1 (start bit 0), ps2_clk_oe=0. Clear the timeout counter. Go to DATA.
- DATA:
  - On each ps2_clk falling edge: present shift[0], shift right, increment the bit counter.
  - ps2_data_oe = ~current bit.
  - Falling edges 1..8 present data bits 0..7. Edge 9 presents parity. Edge 10 presents stop (data released).
  - After edge 10, go to ACK.
- ACK:
  - On the next falling edge (edge 11), sample sync_data. 0 = acked; 1 = set internal err.
  - Go to WAIT_IDLE.
- WAIT_IDLE: wait until sync_clk==1 && sync_data==1, then go to DONE.
- DONE:
  - One cycle: done=1, ack_err=err, timeout=0. Go to IDLE.
  - tx_ready rises the cycle after done.
- Timeout:
  - The counter runs in REQ, DATA, ACK and WAIT_IDLE.
  - When it reaches N_TO = c_clk_mhz*c_timeout_us, release both lines and pulse done=1, timeout=1, ack_err=0 in the same cycle. Go to IDLE.
  - Timeout has priority over a coincident falling edge.
- Counter widths: $clog2(N+1), computed in the package.
- tx_valid while busy is ignored; there is no queue, so the source holds tx_valid.
- Falling edges seen in IDLE or INHIBIT are ignored.
- Lines are only ever driven low, never high.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE, DONE);
  - functions returning N_INH, N_TO and counter widths from the parameters;
  - constant PS2_FRAME_BITS = 10 (8 data + parity + stop shifted after start).
- Sub-module ps2_sync_edge: 2-FF synchroniser plus registered falling-edge pulse for one line. Later shared with the receiver.

Test Plan:
- Send tx_data=0xED with a device BFM clocking at 12.5 kHz:
  - ps2_clk_oe high for exactly 2500 cycles, then ps2_data_oe=1;
  - BFM samples on rising edges start 0, bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1;
  - BFM acks low; done pulses with ack_err=0 and timeout=0.
- Parity check: 0x00 gives parity 1 and 0x01 gives parity 0, each sampled by the BFM on its 10th rising edge.
- BFM never clocks: after exactly 375000 cycles from REQ, done=1 and timeout=1, both oe=0, tx_ready=1 next cycle.
- BFM omits the ack (data stays high on edge 11): done=1, ack_err=1.
- tx_valid held through an entire transfer of 0xFF: exactly one frame is sent. A second frame starts only after done, with INHIBIT entered 2 cycles after done.
- Assert reset on data bit 4: both oe go to 0 asynchronously before the next clk edge, busy=0, tx_ready=1. A fresh 0xF3 then completes with ack_err=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and timing helpers for the PS/2 host transmitter.
package ps2_pkg;

    // state     | meaning
    // IDLE      | ready for a new byte, both lines released
    // INHIBIT   | holding ps2_clk low before the request
    // REQ       | clock released, data pulled low (start bit)
    // DATA      | device clocks out data, parity and stop
    // ACK       | waiting for the device ack edge
    // WAIT_IDLE | waiting for both lines to float high
    // DONE      | one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        ACK,
        WAIT_IDLE,
        DONE
    } state_t;

    // 8 data bits + parity + stop, shifted out after the start bit
    localparam int PS2_FRAME_BITS = 10;

    function automatic int calc_n_inh(input int clk_mhz, input int inhibit_us);
        return clk_mhz * inhibit_us;
    endfunction

    function automatic int calc_n_to(input int clk_mhz, input int timeout_us);
        return clk_mhz * timeout_us;
    endfunction

    function automatic int calc_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ps2_host_tx_sync_edge.sv
// Two-flop synchroniser for one PS/2 line plus a registered falling-edge pulse.
module ps2_sync_edge (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_line,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_fall;

    // Resets to the idle-high level so leaving reset never looks like an edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_fall <= ~r_sync & r_prev;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request, device-clocked shift-out,
// ack check and overall timeout. Lines are only ever pulled low.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int c_clk_mhz    = 25,
    parameter int c_inhibit_us = 100,
    parameter int c_timeout_us = 15000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    input  logic       i_ps2_clk_in,
    input  logic       i_ps2_data_in,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_err,
    output logic       o_timeout
);

    localparam int N_INH = calc_n_inh(c_clk_mhz, c_inhibit_us);
    localparam int N_TO  = calc_n_to(c_clk_mhz, c_timeout_us);
    localparam int W_INH = calc_cnt_w(N_INH);
    localparam int W_TO  = calc_cnt_w(N_TO);

    state_t                    r_state;
    state_t                    w_next;
    logic [W_INH-1:0]          r_inh_cnt;
    logic [W_TO-1:0]           r_to_cnt;
    logic [PS2_FRAME_BITS-1:0] r_shift;
    logic [3:0]                r_bit_cnt;
    logic                      r_cur_bit;
    logic                      r_err;

    logic w_clk_sync;
    logic w_clk_fall;
    logic w_data_sync;
    logic w_data_fall_unused;
    logic w_accept;
    logic w_counting;
    logic w_to_hit;

    ps2_sync_edge u_sync_clk (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_line  (i_ps2_clk_in),
        .o_sync  (w_clk_sync),
        .o_fall  (w_clk_fall)
    );

    ps2_sync_edge u_sync_data (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_line  (i_ps2_data_in),
        .o_sync  (w_data_sync),
        .o_fall  (w_data_fall_unused)
    );

    assign w_accept   = (r_state == IDLE) && i_tx_valid;
    assign w_counting = (r_state == DATA) || (r_state == ACK) || (r_state == WAIT_IDLE);
    // Timeout wins over any falling edge in the same cycle.
    assign w_to_hit   = w_counting && (r_to_cnt == '0);

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Frame datapath: shift register, bit counter, timers and ack capture.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
            r_shift   <= '1;
            r_bit_cnt <= '0;
            r_cur_bit <= 1'b1;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift   <= {1'b1, ~^i_tx_data, i_tx_data};
                r_bit_cnt <= '0;
                r_inh_cnt <= W_INH'(N_INH - 1);
                r_err     <= 1'b0;
            end
            if (r_state == INHIBIT && r_inh_cnt != '0) begin
                r_inh_cnt <= r_inh_cnt - 1'b1;
            end
            if (r_state == REQ) begin
                r_to_cnt  <= W_TO'(N_TO - 1);
                r_cur_bit <= 1'b0;
            end else if (w_counting && r_to_cnt != '0) begin
                r_to_cnt <= r_to_cnt - 1'b1;
            end
            if (r_state == DATA && w_clk_fall && !w_to_hit) begin
                r_cur_bit <= r_shift[0];
                r_shift   <= {1'b1, r_shift[PS2_FRAME_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (r_state == ACK && w_clk_fall && !w_to_hit) begin
                r_err <= w_data_sync;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_next        = r_state;
        o_tx_ready    = 1'b0;
        o_busy        = 1'b1;
        o_ps2_clk_oe  = 1'b0;
        o_ps2_data_oe = 1'b0;
        o_done        = 1'b0;
        o_ack_err     = 1'b0;
        o_timeout     = 1'b0;
        case (r_state)
            IDLE: begin
                o_tx_ready = 1'b1;
                o_busy     = 1'b0;
                if (i_tx_valid) w_next = INHIBIT;
            end
            INHIBIT: begin
                o_ps2_clk_oe = 1'b1;
                if (r_inh_cnt == '0) w_next = REQ;
            end
            REQ: begin
                o_ps2_data_oe = 1'b1;
                w_next        = DATA;
            end
            DATA: begin
                o_ps2_data_oe = ~r_cur_bit;
                if (w_clk_fall && r_bit_cnt == 4'(PS2_FRAME_BITS - 1)) w_next = ACK;
            end
            ACK: begin
                if (w_clk_fall) w_next = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (w_clk_sync && w_data_sync) w_next = DONE;
            end
            DONE: begin
                o_done    = 1'b1;
                o_ack_err = r_err;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (w_to_hit) begin
            w_next        = IDLE;
            o_ps2_clk_oe  = 1'b0;
            o_ps2_data_oe = 1'b0;
            o_done        = 1'b1;
            o_timeout     = 1'b1;
            o_ack_err     = 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain device model.
// Timeout shortened to 400 us and device clock sped up to keep the run short.
module tb_ps2_host_tx;

    localparam int HALF  = 100;
    localparam int N_INH = 2500;
    localparam int N_TO  = 10000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       tx_ready, clk_oe, data_oe, busy, done, ack_err, timeout;
    wire        clk_line  = ~(clk_oe | dev_clk_low);
    wire        data_line = ~(data_oe | dev_data_low);

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cyc = 0;

    ps2_host_tx #(
        .c_clk_mhz    (25),
        .c_inhibit_us (100),
        .c_timeout_us (400)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_tx_data     (tx_data),
        .i_tx_valid    (tx_valid),
        .o_tx_ready    (tx_ready),
        .i_ps2_clk_in  (clk_line),
        .i_ps2_data_in (data_line),
        .o_ps2_clk_oe  (clk_oe),
        .o_ps2_data_oe (data_oe),
        .o_busy        (busy),
        .o_done        (done),
        .o_ack_err     (ack_err),
        .o_timeout     (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_req(output int inh_cycles, output bit seen);
        inh_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            if (data_oe) seen = 1'b1;
            else if (clk_oe) inh_cycles++;
        end
    endtask

    // Device: samples data at the end of each high phase, then pulls clk low.
    task automatic clock_bits(input int n, input bit do_ack, output logic [10:0] bits, output bit clk_driven);
        bits = '1;
        clk_driven = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat (HALF) begin
                @(negedge clk);
                if (clk_oe) clk_driven = 1'b1;
            end
            bits[i] = data_line;
            if (i == 10) begin
                if (do_ack) dev_data_low = 1'b1;
                repeat (10) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(output bit seen, output logic ae, output logic to);
        seen = 1'b0;
        ae = 1'b0;
        to = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                ae = ack_err;
                to = timeout;
                done_cyc = cyc;
            end
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input logic par,
                             input bit do_ack, input bit check_inh, input logic exp_err);
        int         inh;
        bit         seen;
        bit         drv;
        logic [10:0] bits;
        logic       ae, to;
        wait_req(inh, seen);
        check({tag, " req"}, 32'(seen), 1);
        if (check_inh) check({tag, " inhibit"}, inh, N_INH);
        clock_bits(11, do_ack, bits, drv);
        check({tag, " frame"}, 32'(bits), 32'({1'b1, par, d, 1'b0}));
        check({tag, " clk_oe"}, 32'(drv), 0);
        wait_done(seen, ae, to);
        check({tag, " done"}, 32'(seen), 1);
        check({tag, " ack_err"}, 32'(ae), 32'(exp_err));
        check({tag, " timeout"}, 32'(to), 0);
        @(negedge clk);
        check({tag, " ready"}, 32'(tx_ready), 1);
    endtask

    initial begin : stim
        int          inh, t0;
        bit          seen, drv;
        logic [10:0] bits;
        logic        got_to, got_ae, got_clk, got_data;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst clk_oe", 32'(clk_oe), 0);
        check("rst data_oe", 32'(data_oe), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst ack_err", 32'(ack_err), 0);
        check("rst timeout", 32'(timeout), 0);
        check("rst ready", 32'(tx_ready), 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // LED command with ack
        start_tx(8'hED);
        run_frame("ed", 8'hED, 1'b1, 1'b1, 1'b1, 1'b0);

        // Parity extremes
        start_tx(8'h00);
        run_frame("p00", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        start_tx(8'h01);
        run_frame("p01", 8'h01, 1'b0, 1'b1, 1'b1, 1'b0);

        // Missing ack
        start_tx(8'hF4);
        run_frame("noack", 8'hF4, 1'b0, 1'b0, 1'b1, 1'b1);

        // Device never clocks
        start_tx(8'h5A);
        wait_req(inh, seen);
        check("to req", 32'(seen), 1);
        t0 = cyc;
        seen = 1'b0;
        got_to = 1'b0; got_ae = 1'b1; got_clk = 1'b1; got_data = 1'b1;
        for (int i = 0; i < N_TO + 50 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
                got_to = timeout; got_ae = ack_err; got_clk = clk_oe; got_data = data_oe;
            end
        end
        check("to done", 32'(seen), 1);
        check("to cycles", done_cyc - t0, N_TO);
        check("to flag", 32'(got_to), 1);
        check("to ack_err", 32'(got_ae), 0);
        check("to clk_oe", 32'(got_clk), 0);
        check("to data_oe", 32'(got_data), 0);
        @(negedge clk);
        check("to ready", 32'(tx_ready), 1);
        check("to busy", 32'(busy), 0);

        // tx_valid held across a whole 0xFF transfer
        @(negedge clk);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        run_frame("hold1", 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (clk_oe) seen = 1'b1;
            else @(negedge clk);
        end
        check("hold gap", cyc - done_cyc, 2);
        tx_valid = 1'b0;
        run_frame("hold2", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("hold no third", 32'(clk_oe), 0);
        check("hold idle", 32'(busy), 0);

        // Reset while data bit 4 is on the line
        start_tx(8'hE1);
        wait_req(inh, seen);
        check("rstmid req", 32'(seen), 1);
        clock_bits(5, 1'b0, bits, drv);
        check("rstmid bits", 32'(bits[4:0]), 32'h2);
        check("rstmid bit4 driven", 32'(data_oe), 1);
        #2 rst = 1'b1;
        #1;
        check("rstmid clk_oe", 32'(clk_oe), 0);
        check("rstmid data_oe", 32'(data_oe), 0);
        check("rstmid busy", 32'(busy), 0);
        check("rstmid ready", 32'(tx_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        start_tx(8'hF3);
        run_frame("f3", 8'hF3, 1'b1, 1'b1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
